// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: FSM state encoding
// and the index-width helper used by the address generators.
package matrix_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Result-memory read port plus valid/ready byte stream.
// The streamer is the master of both.
interface matrix_result_streamer_if #(
   parameter int RW     = 3,
   parameter int CW     = 3,
   parameter int DATA_W = 32
);

   logic              rd_en;
   logic [RW-1:0]     rd_row;
   logic [CW-1:0]     rd_col;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        out_byte;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rd_en, rd_row, rd_col,
      input  rd_data,
      output out_byte, out_valid,
      input  out_ready
   );

   modport slave (
      input  rd_en, rd_row, rd_col,
      output rd_data,
      input  out_byte, out_valid,
      output out_ready
   );

endinterface

// File: rtl/matrix_index_walker.sv
// Row/column counters walking a ROWS x COLS matrix in either order;
// o_last flags the final element (ROWS-1, COLS-1).
module matrix_index_walker
   import matrix_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int RW   = idx_w(ROWS),
   parameter int CW   = idx_w(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_col_major,
   input  logic          i_advance,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_col,
   output logic          o_last
);

   localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          w_row_end;
   logic          w_col_end;

   assign w_row_end = (r_row == R_MAX);
   assign w_col_end = (r_col == C_MAX);

   // Single-value dimensions wrap straight back to 0.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         if (i_col_major) begin
            r_row <= w_row_end ? '0 : r_row + 1'b1;
            if (w_row_end)
               r_col <= w_col_end ? '0 : r_col + 1'b1;
         end else begin
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_col_end)
               r_row <= w_row_end ? '0 : r_row + 1'b1;
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = w_row_end && w_col_end;

endmodule

// File: rtl/matrix_result_streamer.sv
// Reads each matrix element from the result memory and streams it
// MSB byte first over a valid/ready port, pulsing done at the end.
module matrix_result_streamer
   import matrix_pkg::*;
#(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1,
   parameter int RW     = idx_w(ROWS),
   parameter int CW     = idx_w(COLS)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic col_major,
   matrix_result_streamer_if.master bus,
   output logic busy,
   output logic done
);

   localparam int NB = DATA_W / 8;
   localparam int BW = idx_w(NB);

   state_t            r_state;
   state_t            w_next;
   logic              r_cm;
   logic [1:0]        r_lat;
   logic [BW-1:0]     r_bcnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_out_valid;
   logic              w_accept;
   logic              w_adv;
   logic              w_clear;
   logic              w_last;

   matrix_index_walker #(
      .ROWS (ROWS),
      .COLS (COLS),
      .RW   (RW),
      .CW   (CW)
   ) u_walker (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_clear),
      .i_col_major (r_cm),
      .i_advance   (w_adv),
      .o_row       (bus.rd_row),
      .o_col       (bus.rd_col),
      .o_last      (w_last)
   );

   assign w_accept = r_out_valid && bus.out_ready;

   always_comb begin
      w_next  = r_state;
      w_adv   = 1'b0;
      w_clear = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = S_READ;
            end
         end
         S_READ: w_next = S_WAIT;
         S_WAIT: begin
            if (r_lat == '0)
               w_next = S_SEND;
         end
         S_SEND: begin
            if (w_accept && (r_bcnt == '0)) begin
               if (w_last) begin
                  w_next = S_DONE;
               end else begin
                  w_adv  = 1'b1;
                  w_next = S_READ;
               end
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cm        <= 1'b0;
         r_lat       <= '0;
         r_bcnt      <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_valid <= (w_next == S_SEND);
         if ((r_state == S_IDLE) && start)
            r_cm <= col_major;
         if (r_state == S_READ)
            r_lat <= 2'(RD_LAT - 1);
         if (r_state == S_WAIT) begin
            if (r_lat == '0) begin
               r_shift <= bus.rd_data;
               r_bcnt  <= BW'(NB - 1);
            end else begin
               r_lat <= r_lat - 2'd1;
            end
         end
         if ((r_state == S_SEND) && w_accept) begin
            r_shift <= r_shift << 8;
            r_bcnt  <= r_bcnt - 1'b1;
         end
      end
   end

   assign bus.rd_en     = (r_state == S_READ);
   assign bus.out_byte  = r_shift[DATA_W-1 -: 8];
   assign bus.out_valid = r_out_valid;
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: three configurations checked
// against fixed vectors and a queue-based element-order model.
module tb_matrix_result_streamer;
   import matrix_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      int           inst;
      bit           cm;
      int           nb;
      logic [127:0] bytes;
      int           done_n;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic st_a, st_b, st_c;
   logic cm_a, cm_b, cm_c;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;

   int total = 0;
   int bad   = 0;
   int rdc[3] = '{0, 0, 0};
   int dnc[3] = '{0, 0, 0};
   byte_q_t qa, qb, qc;

   logic [31:0] memb[9];
   logic [15:0] memc[4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
   bit          rand_b = 1'b0;
   logic [31:0] b1, b2;
   logic        pst_b = 1'b0;
   logic [7:0]  pby_b = 8'h0;

   matrix_result_streamer_if #(.RW(1), .CW(1), .DATA_W(32)) if_a ();
   matrix_result_streamer_if #(.RW(2), .CW(2), .DATA_W(32)) if_b ();
   matrix_result_streamer_if #(.RW(1), .CW(2), .DATA_W(16)) if_c ();

   matrix_result_streamer #(
      .ROWS(2), .COLS(2), .DATA_W(32), .RD_LAT(1)
   ) dut_a (
      .clk(clk), .rst(rst_a), .start(st_a), .col_major(cm_a),
      .bus(if_a), .busy(busy_a), .done(done_a)
   );

   matrix_result_streamer #(
      .ROWS(3), .COLS(3), .DATA_W(32), .RD_LAT(3)
   ) dut_b (
      .clk(clk), .rst(rst_b), .start(st_b), .col_major(cm_b),
      .bus(if_b), .busy(busy_b), .done(done_b)
   );

   matrix_result_streamer #(
      .ROWS(1), .COLS(4), .DATA_W(16), .RD_LAT(1)
   ) dut_c (
      .clk(clk), .rst(rst_c), .start(st_c), .col_major(cm_c),
      .bus(if_c), .busy(busy_c), .done(done_c)
   );

   function automatic logic [31:0] mem_val(int i, int r, int c);
      case (i)
         0:       return 32'(r * 16 + c);
         1:       return memb[r * 3 + c];
         default: return {16'h0, memc[c]};
      endcase
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Memory models: data appears only RD_LAT cycles after a strobe.
   always @(posedge clk) begin
      if_a.rd_data <= if_a.rd_en ?
         mem_val(0, int'(if_a.rd_row), int'(if_a.rd_col)) : 32'hDEAD_BEEF;
      b1 <= if_b.rd_en ?
         mem_val(1, int'(if_b.rd_row), int'(if_b.rd_col)) : 32'hDEAD_BEEF;
      b2 <= b1;
      if_b.rd_data <= b2;
      if_c.rd_data <= if_c.rd_en ?
         16'(mem_val(2, int'(if_c.rd_row), int'(if_c.rd_col))) : 16'hDEAD;
   end

   always @(posedge clk) begin
      #1;
      if_b.out_ready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (if_a.out_valid && if_a.out_ready) qa.push_back(if_a.out_byte);
      if (if_b.out_valid && if_b.out_ready) qb.push_back(if_b.out_byte);
      if (if_c.out_valid && if_c.out_ready) qc.push_back(if_c.out_byte);
      if (if_a.rd_en) rdc[0]++;
      if (if_b.rd_en) rdc[1]++;
      if (if_c.rd_en) rdc[2]++;
      if (done_a) dnc[0]++;
      if (done_b) dnc[1]++;
      if (done_c) dnc[2]++;
      if (pst_b)
         chk("stall_hold_b", {if_b.out_valid, if_b.out_byte},
             {1'b1, pby_b});
      pst_b = if_b.out_valid && !if_b.out_ready;
      pby_b = if_b.out_byte;
   end

   // Expected stream straight from traversal order and byte order.
   task automatic model(input int i, input bit cm, output byte_q_t q);
      int nr, nc, nb;
      nr = (i == 0) ? 2 : (i == 1) ? 3 : 1;
      nc = (i == 0) ? 2 : (i == 1) ? 3 : 4;
      nb = (i == 2) ? 2 : 4;
      q = {};
      for (int e = 0; e < nr * nc; e++) begin
         int r, c;
         logic [31:0] v;
         r = cm ? e % nr : e / nc;
         c = cm ? e / nr : e % nc;
         v = mem_val(i, r, c);
         for (int b = nb - 1; b >= 0; b--)
            q.push_back(8'(v >> (8 * b)));
      end
   endtask

   function automatic logic get_done(int i);
      case (i)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic get_busy(int i);
      case (i)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic get_q(input int i, output byte_q_t q);
      case (i)
         0:       q = qa;
         1:       q = qb;
         default: q = qc;
      endcase
   endtask

   task automatic clr_q(input int i);
      case (i)
         0:       qa = {};
         1:       qb = {};
         default: qc = {};
      endcase
   endtask

   task automatic drive(input int i, input logic s, input logic cm);
      case (i)
         0:       begin st_a = s; cm_a = cm; end
         1:       begin st_b = s; cm_b = cm; end
         default: begin st_c = s; cm_c = cm; end
      endcase
   endtask

   // Entered and left at #1 after a rising edge, DUT idle.
   task automatic run_dump(input int i, input bit cm, input byte_q_t exp,
                           input int done_n, output byte_q_t got);
      int n, r0, d0, nb;
      nb = (i == 2) ? 2 : 4;
      r0 = rdc[i];
      d0 = dnc[i];
      clr_q(i);
      drive(i, 1'b1, cm);
      @(posedge clk);
      #1 drive(i, 1'b0, ~cm);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!get_done(i) && n < 3000);
      if (done_n > 0)
         chk($sformatf("done_cycle_i%0d", i), n, done_n);
      @(posedge clk);
      #1 chk($sformatf("busy_after_done_i%0d", i), get_busy(i), 0);
      get_q(i, got);
      chk($sformatf("byte_count_i%0d", i), got.size(), exp.size());
      for (int j = 0; j < exp.size() && j < got.size(); j++)
         chk($sformatf("byte%0d_i%0d_cm%0d", j, i, cm), got[j], exp[j]);
      chk($sformatf("rd_en_count_i%0d", i), rdc[i] - r0, exp.size() / nb);
      chk($sformatf("done_count_i%0d", i), dnc[i] - d0, 1);
   endtask

   initial begin
      vec_t    tv[4];
      byte_q_t e, g1, g2;
      int      n, r0, d0, sz;

      tv[0] = '{0, 1'b0, 16, 128'h00000000_00000001_00000010_00000011, 25};
      tv[1] = '{0, 1'b1, 16, 128'h00000000_00000010_00000001_00000011, 25};
      tv[2] = '{2, 1'b0, 8, 128'hA1B2C3D4E5F60718, 17};
      tv[3] = '{2, 1'b1, 8, 128'hA1B2C3D4E5F60718, 17};

      for (int k = 0; k < 9; k++) memb[k] = $urandom;
      if_a.out_ready = 1'b1;
      if_c.out_ready = 1'b1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      drive(2, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_a", {if_a.rd_en, if_a.rd_row, if_a.rd_col, if_a.out_byte,
                      if_a.out_valid, busy_a, done_a}, 0);
      chk("reset_b", {if_b.rd_en, if_b.rd_row, if_b.rd_col, if_b.out_byte,
                      if_b.out_valid, busy_b, done_b}, 0);
      chk("reset_c", {if_c.rd_en, if_c.rd_row, if_c.rd_col, if_c.out_byte,
                      if_c.out_valid, busy_c, done_c}, 0);
      @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Fixed vectors; consecutive entries also start right after DONE.
      for (int k = 0; k < 4; k++) begin
         e = {};
         for (int j = 0; j < tv[k].nb; j++)
            e.push_back(tv[k].bytes[(tv[k].nb - 1 - j) * 8 +: 8]);
         run_dump(tv[k].inst, tv[k].cm, e, tv[k].done_n, g1);
      end

      model(1, 1'b0, e);
      rand_b = 1'b0;
      run_dump(1, 1'b0, e, 1 + 9 * (1 + 3 + 4), g1);
      rand_b = 1'b1;
      run_dump(1, 1'b0, e, 0, g2);
      for (int j = 0; j < g1.size() && j < g2.size(); j++)
         chk($sformatf("bp_same%0d", j), g2[j], g1[j]);
      for (int k = 0; k < 9; k++) memb[k] = $urandom;
      model(1, 1'b1, e);
      run_dump(1, 1'b1, e, 0, g2);
      rand_b = 1'b0;

      // start pulsed mid-SEND must be ignored.
      r0 = rdc[0];
      d0 = dnc[0];
      clr_q(0);
      drive(0, 1'b1, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0);
      n = 0;
      while (qa.size() < 6 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 drive(0, 1'b1, 1'b1);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_a && n < 500);
      repeat (8) @(negedge clk);
      chk("midsend_bytes", qa.size(), 16);
      chk("midsend_done", dnc[0] - d0, 1);
      chk("midsend_rd_en", rdc[0] - r0, 4);
      chk("midsend_busy", busy_a, 0);
      @(posedge clk);
      #1;

      // Reset after the fifth accepted byte.
      d0 = dnc[0];
      clr_q(0);
      drive(0, 1'b1, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0);
      n = 0;
      while (qa.size() < 5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 rst_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_state", {if_a.out_valid, busy_a, done_a}, 0);
      r0 = rdc[0];
      sz = qa.size();
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_no_rd_en", rdc[0] - r0, 0);
      chk("rst_no_done", dnc[0] - d0, 0);
      chk("rst_no_bytes", qa.size(), sz);
      @(posedge clk);
      #1;
      model(0, 1'b0, e);
      run_dump(0, 1'b0, e, 25, g1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
